// File: rtl/systolic_2by2_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the 2x2 systolic operand feeder:
//   W          - default operand lane width (matches the array's 8-bit lanes)
//   N          - array dimension (2x2)
//   BANK_DEPTH - number of operand registers (one A and one B matrix)
//   SEL_W      - width of the operand write select
//   state_t    - feeder FSM states
//   SEL_*      - wr_sel encodings for each matrix element
//   bank_idx() - maps (matrix, row, col) onto a flat bank index
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int W          = 8;
    localparam int N          = 2;
    localparam int BANK_DEPTH = 2 * N * N;
    localparam int SEL_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [SEL_W-1:0] SEL_A00 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_A01 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_A10 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_A11 = 3'd3;
    localparam logic [SEL_W-1:0] SEL_B00 = 3'd4;
    localparam logic [SEL_W-1:0] SEL_B01 = 3'd5;
    localparam logic [SEL_W-1:0] SEL_B10 = 3'd6;
    localparam logic [SEL_W-1:0] SEL_B11 = 3'd7;

    // A occupies indices 0..3 (row-major), B occupies 4..7 (row-major).
    function automatic logic [SEL_W-1:0] bank_idx(input logic is_b,
                                                 input int   row,
                                                 input int   col);
        int flat;
        flat = (is_b ? N * N : 0) + row * N + col;
        return SEL_W'(flat);
    endfunction

endpackage

// File: rtl/systolic_2by2_feeder_operand_bank.sv
// -----------------------------------------------------------------------------
// operand_bank
// Eight-entry W-bit register file holding one 2x2 A and one 2x2 B matrix.
// One write port, all entries readable in parallel every cycle.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears every entry to 0
//   wr_en    - write strobe (already qualified by the caller)
//   wr_sel   - entry to write (SEL_A00..SEL_B11)
//   wr_data  - value to write
//   rd_data  - all entries, rd_data[i] is entry i
// -----------------------------------------------------------------------------
module operand_bank #(
    parameter int W = systolic_pkg::W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  wr_en,
    input  logic [systolic_pkg::SEL_W-1:0]        wr_sel,
    input  logic [W-1:0]                          wr_data,
    output logic [systolic_pkg::BANK_DEPTH-1:0][W-1:0] rd_data
);

    import systolic_pkg::*;

    // Registers rather than a RAM: the skew mux needs several entries
    // in the same cycle.
    for (genvar gi = 0; gi < BANK_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data[gi] <= '0;
            end else if (wr_en && (wr_sel == SEL_W'(gi))) begin
                rd_data[gi] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/systolic_2by2_feeder.sv
// -----------------------------------------------------------------------------
// systolic_2by2_feeder
// Holds one 2x2 A and one 2x2 B operand matrix and streams them, diagonally
// skewed, into a 2x2 systolic array. Each pass is 3 data steps followed by
// FLUSH all-zero cycles, then a one-cycle done pulse.
// Ports:
//   clk              - clock, rising edge
//   rst              - synchronous active-high reset
//   wr_en/wr_sel/wr_data - operand write port (accepted in IDLE and DONE)
//   start            - begin a pass (sampled only in IDLE, wins over a write)
//   left1, left2     - row 0 / row 1 operand streams
//   up1, up2         - column 0 / column 1 operand streams
//   strobe           - high during data-phase cycles
//   busy             - high during data and flush cycles
//   done             - one-cycle pulse after the last flush cycle
// All outputs are registered.
// -----------------------------------------------------------------------------
module systolic_2by2_feeder #(
    parameter int W     = systolic_pkg::W,
    parameter int FLUSH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [2:0]   wr_sel,
    input  logic [W-1:0] wr_data,
    input  logic         start,
    output logic [W-1:0] left1,
    output logic [W-1:0] left2,
    output logic [W-1:0] up1,
    output logic [W-1:0] up2,
    output logic         strobe,
    output logic         busy,
    output logic         done
);

    import systolic_pkg::*;

    // Steps 0..2N-2 cover the full diagonal skew of an NxN product.
    localparam logic [1:0] LAST_STEP  = 2'(2 * N - 2);
    localparam logic [3:0] FLUSH_LAST = (FLUSH > 0) ? 4'(FLUSH - 1) : 4'd0;

    state_t       state_reg, state_next;
    logic [1:0]   step_reg, step_next;
    logic [3:0]   flush_cnt_reg, flush_cnt_next;

    logic [W-1:0] left1_next, left2_next, up1_next, up2_next;
    int           step_i;

    logic                        bank_wr_en;
    logic [BANK_DEPTH-1:0][W-1:0] bank_q;

    // The bank is frozen while a pass is in flight; a start in IDLE takes
    // priority over a simultaneous write, so that write is dropped.
    assign bank_wr_en = wr_en &&
                        (((state_reg == ST_IDLE) && !start) || (state_reg == ST_DONE));

    operand_bank #(
        .W (W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .rd_data (bank_q)
    );

    // Next-state logic. The registers describe what is being shown this
    // cycle, so outputs below are derived from the *next* state/step.
    always_comb begin
        state_next     = state_reg;
        step_next      = step_reg;
        flush_cnt_next = flush_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_STREAM;
                    step_next  = '0;
                end
            end
            ST_STREAM: begin
                if (step_reg == LAST_STEP) begin
                    if (FLUSH == 0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next     = ST_FLUSH;
                        flush_cnt_next = '0;
                    end
                end else begin
                    step_next = step_reg + 2'd1;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_reg == FLUSH_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    flush_cnt_next = flush_cnt_reg + 4'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Skew mux: row r / column c is delayed by r / c steps; indices that
    // fall outside the matrix drive zero.
    always_comb begin
        step_i     = int'(step_next);
        left1_next = '0;
        left2_next = '0;
        up1_next   = '0;
        up2_next   = '0;
        if (state_next == ST_STREAM) begin
            if (step_i < N) begin
                left1_next = bank_q[bank_idx(1'b0, 0, step_i)];
                up1_next   = bank_q[bank_idx(1'b1, step_i, 0)];
            end
            if ((step_i >= 1) && (step_i <= N)) begin
                left2_next = bank_q[bank_idx(1'b0, 1, step_i - 1)];
                up2_next   = bank_q[bank_idx(1'b1, step_i - 1, 1)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            step_reg      <= '0;
            flush_cnt_reg <= '0;
            left1         <= '0;
            left2         <= '0;
            up1           <= '0;
            up2           <= '0;
            strobe        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            step_reg      <= step_next;
            flush_cnt_reg <= flush_cnt_next;
            left1         <= left1_next;
            left2         <= left2_next;
            up1           <= up1_next;
            up2           <= up2_next;
            strobe        <= (state_next == ST_STREAM);
            busy          <= (state_next == ST_STREAM) || (state_next == ST_FLUSH);
            done          <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_systolic_2by2_feeder.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for systolic_2by2_feeder. Two instances share stimulus:
// inst 0 with FLUSH=2 and inst 1 with FLUSH=0. A driver updates a behavioural
// model after every clock edge and queues timestamped expected outputs; a
// monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_systolic_2by2_feeder;

    localparam int W = 8;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [W-1:0] l1;
        logic [W-1:0] l2;
        logic [W-1:0] u1;
        logic [W-1:0] u2;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_sel = 3'd0;
    logic [W-1:0] wr_data = '0;
    logic         start = 1'b0;

    logic [W-1:0] l1_a, l2_a, u1_a, u2_a;
    logic [W-1:0] l1_b, l2_b, u1_b, u2_b;
    logic         strobe_a, busy_a, done_a;
    logic         strobe_b, busy_b, done_b;

    systolic_2by2_feeder #(.W(W), .FLUSH(2)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .start(start), .left1(l1_a), .left2(l2_a), .up1(u1_a), .up2(u2_a),
        .strobe(strobe_a), .busy(busy_a), .done(done_a)
    );

    systolic_2by2_feeder #(.W(W), .FLUSH(0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .start(start), .left1(l1_b), .left2(l2_b), .up1(u1_b), .up2(u2_b),
        .strobe(strobe_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; outputs seen at the falling edge
    // with cyc == e are the ones produced by edge e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state per instance
    exp_t         q[2][$];
    int           pass_edge[2];
    logic [W-1:0] bank[2][8];
    int           flush_len[2];
    int           errors = 0;
    int           checks = 0;
    bit           mon_en = 1'b0;

    function automatic logic [W-1:0] mat_a(input int i, input int r, input int c);
        if (r < 0 || r > 1 || c < 0 || c > 1) return '0;
        return bank[i][2 * r + c];
    endfunction

    function automatic logic [W-1:0] mat_b(input int i, input int r, input int c);
        if (r < 0 || r > 1 || c < 0 || c > 1) return '0;
        return bank[i][4 + 2 * r + c];
    endfunction

    // Apply the effect of rising edge e with the given input values.
    task automatic model_edge(input int e, input bit r, input bit s, input bit we,
                              input int sel, input int d);
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                for (int k = 0; k < 8; k++) bank[i][k] = '0;
                q[i].delete();
                pass_edge[i] = -1000;
            end else if (s && (e >= pass_edge[i] + 5 + flush_len[i])) begin
                // accepted start: 3 skewed data steps then a done pulse
                for (int t = 0; t < 3; t++) begin
                    x.cyc = e + t;
                    x.is_done = 1'b0;
                    x.l1 = mat_a(i, 0, t);
                    x.l2 = mat_a(i, 1, t - 1);
                    x.u1 = mat_b(i, t, 0);
                    x.u2 = mat_b(i, t - 1, 1);
                    q[i].push_back(x);
                end
                x.cyc = e + 3 + flush_len[i];
                x.is_done = 1'b1;
                x.l1 = '0; x.l2 = '0; x.u1 = '0; x.u2 = '0;
                q[i].push_back(x);
                pass_edge[i] = e;
            end else if (we && (e >= pass_edge[i] + 4 + flush_len[i])) begin
                bank[i][sel] = W'(d);
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit we, input int sel, input int d);
        rst = r; start = s; wr_en = we; wr_sel = 3'(sel); wr_data = W'(d);
        @(posedge clk);
        #1;
        model_edge(cyc, r, s, we, sel, d);
    endtask

    task automatic check_inst(input int i, input logic [W-1:0] l1, input logic [W-1:0] l2,
                              input logic [W-1:0] u1, input logic [W-1:0] u2,
                              input logic st, input logic dn, input logic bz);
        exp_t x;
        bit   exp_busy;
        while (q[i].size() > 0 && q[i][0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_output inst%0d cyc=%0d got=none want=output_at_cyc_%0d",
                     i, cyc, q[i][0].cyc);
            void'(q[i].pop_front());
        end
        exp_busy = (cyc >= pass_edge[i]) && (cyc <= pass_edge[i] + 2 + flush_len[i]);
        checks++;
        if (bz !== exp_busy) begin
            errors++;
            $display("FAIL busy inst%0d cyc=%0d got=%b want=%b", i, cyc, bz, exp_busy);
        end
        if (st || dn) begin
            checks++;
            if (q[i].size() == 0 || q[i][0].cyc != cyc) begin
                errors++;
                $display("FAIL unexpected_output inst%0d cyc=%0d got strobe=%b done=%b want=idle",
                         i, cyc, st, dn);
            end else begin
                x = q[i].pop_front();
                if (st !== !x.is_done || dn !== x.is_done ||
                    l1 !== x.l1 || l2 !== x.l2 || u1 !== x.u1 || u2 !== x.u2) begin
                    errors++;
                    $display("FAIL %s inst%0d cyc=%0d got st=%b dn=%b (%0d,%0d,%0d,%0d) want st=%b dn=%b (%0d,%0d,%0d,%0d)",
                             x.is_done ? "done_pulse" : "data_step", i, cyc, st, dn,
                             l1, l2, u1, u2, !x.is_done, x.is_done, x.l1, x.l2, x.u1, x.u2);
                end
            end
        end else begin
            checks++;
            if (l1 !== '0 || l2 !== '0 || u1 !== '0 || u2 !== '0) begin
                errors++;
                $display("FAIL idle_zero inst%0d cyc=%0d got=(%0d,%0d,%0d,%0d) want=(0,0,0,0)",
                         i, cyc, l1, l2, u1, u2);
            end
            if (q[i].size() > 0 && q[i][0].cyc == cyc) begin
                checks++; errors++;
                $display("FAIL missing_output inst%0d cyc=%0d got=none want=%s",
                         i, cyc, q[i][0].is_done ? "done" : "data");
                void'(q[i].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_inst(0, l1_a, l2_a, u1_a, u2_a, strobe_a, done_a, busy_a);
            check_inst(1, l1_b, l2_b, u1_b, u2_b, strobe_b, done_b, busy_b);
        end
    end

    initial begin
        flush_len[0] = 2;
        flush_len[1] = 0;
        for (int i = 0; i < 2; i++) begin
            pass_edge[i] = -1000;
            for (int k = 0; k < 8; k++) bank[i][k] = '0;
        end

        // Reset
        step(1, 0, 0, 0, 0);
        mon_en = 1'b1;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Basic pass: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        for (int k = 0; k < 8; k++) step(0, 0, 1, k, k + 1);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);

        // Start held high through a whole pass
        for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);

        // Writes during STREAM are ignored; replay shows the same operands
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 9);
        step(0, 0, 1, 0, 9);
        for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0);

        // Start and write in the same IDLE cycle: write dropped
        step(0, 1, 1, 0, 7);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 0);

        // Reset during step 1, then a pass over the cleared bank
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 255)));
        end

        // Drain and make sure nothing expected is left outstanding
        for (int k = 0; k < 12; k++) step(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                errors++;
                $display("FAIL leftover inst%0d got=%0d pending want=0", i, q[i].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
